// File: rtl/iomem_gpio_bank.sv
// rtl/iomem_gpio_bank.sv - PicoSoC iomem GPIO bank: OUT/DIR/IN, edge-capture interrupt, optional PWM
// Define GPIO_PWM_EN to add the free-running PWM counter, PWM_SEL and DUTY[i] registers.
module iomem_gpio_bank #(
   parameter logic [7:0] BASE_HI  = 8'h03,
   parameter int         NUM_PINS = 16,
   parameter int         PWM_BITS = 8
) (
   input  logic                clk2,
   input  logic                resetn,
   input  logic                iomem_valid,
   output logic                iomem_ready,
   input  logic [3:0]          iomem_wstrb,
   input  logic [31:0]         iomem_addr,
   input  logic [31:0]         iomem_wdata,
   output logic [31:0]         iomem_rdata,
   input  logic [NUM_PINS-1:0] gpio_in,
   output logic [NUM_PINS-1:0] gpio_out,
   output logic [NUM_PINS-1:0] gpio_oe,
   output logic                irq
);

   localparam logic [5:0] W_OUT    = 6'h00;
   localparam logic [5:0] W_DIR    = 6'h01;
   localparam logic [5:0] W_IN     = 6'h02;
   localparam logic [5:0] W_RISE   = 6'h03;
   localparam logic [5:0] W_FALL   = 6'h04;
   localparam logic [5:0] W_STATUS = 6'h05;

   logic                sel;
   logic                wr;
   logic [5:0]          word;
   logic [31:0]         lane_mask;
   logic [NUM_PINS-1:0] wmask;
   logic [NUM_PINS-1:0] wbits;
   logic [31:0]         rd_val;

   logic [NUM_PINS-1:0] out_r;
   logic [NUM_PINS-1:0] dir_r;
   logic [NUM_PINS-1:0] rise_en;
   logic [NUM_PINS-1:0] fall_en;
   logic [NUM_PINS-1:0] status;
   logic [NUM_PINS-1:0] s1;
   logic [NUM_PINS-1:0] s2;
   logic [NUM_PINS-1:0] s3;
   logic [NUM_PINS-1:0] rise;
   logic [NUM_PINS-1:0] fall;
   logic [NUM_PINS-1:0] edge_set;
   logic [NUM_PINS-1:0] w1c;
   logic [1:0]          arm;
   logic                armed;
   logic                unused_ok;

`ifdef GPIO_PWM_EN
   localparam logic [5:0] W_PWMSEL = 6'h06;

   logic [PWM_BITS-1:0] cnt;
   logic [NUM_PINS-1:0] pwm_sel;
   logic [NUM_PINS-1:0] pwm_q;
   logic [PWM_BITS-1:0] duty [NUM_PINS];
   logic [PWM_BITS-1:0] duty_mask;
   logic [PWM_BITS-1:0] duty_bits;
`endif

   assign sel       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_HI);
   assign wr        = sel && (iomem_wstrb != 4'b0000);
   assign word      = iomem_addr[7:2];
   assign lane_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                       {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
   assign wmask     = lane_mask[NUM_PINS-1:0];
   assign wbits     = iomem_wdata[NUM_PINS-1:0];
   assign unused_ok = ^{iomem_addr[23:8], iomem_addr[1:0], iomem_wdata, lane_mask};

   // Edges are masked until the synchroniser has been filled with real pad samples.
   assign armed    = (arm == 2'd3);
   assign rise     = armed ? (s2 & ~s3) : '0;
   assign fall     = armed ? (~s2 & s3) : '0;
   assign edge_set = (rise & rise_en) | (fall & fall_en);
   assign w1c      = (wr && (word == W_STATUS)) ? (wbits & wmask) : '0;

   assign gpio_oe  = dir_r;

   always_comb begin
      rd_val = '0;
      case (word)
         W_OUT:    rd_val = 32'(out_r);
         W_DIR:    rd_val = 32'(dir_r);
         W_IN:     rd_val = 32'(s2);
         W_RISE:   rd_val = 32'(rise_en);
         W_FALL:   rd_val = 32'(fall_en);
         W_STATUS: rd_val = 32'(status);
`ifdef GPIO_PWM_EN
         W_PWMSEL: rd_val = 32'(pwm_sel);
`endif
         default:  rd_val = '0;
      endcase
`ifdef GPIO_PWM_EN
      for (int i = 0; i < NUM_PINS; i++) begin
         if (word == 6'(16 + i)) rd_val = 32'(duty[i]);
      end
`endif
   end

   always_ff @(posedge clk2) begin
      if (!resetn) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         out_r       <= '0;
         dir_r       <= '0;
         rise_en     <= '0;
         fall_en     <= '0;
         status      <= '0;
         s1          <= '0;
         s2          <= '0;
         s3          <= '0;
         arm         <= 2'd0;
         irq         <= 1'b0;
      end else begin
         iomem_ready <= sel;
         if (sel) iomem_rdata <= rd_val;
         s1 <= gpio_in;
         s2 <= s1;
         s3 <= s2;
         if (!armed) arm <= arm + 2'd1;
         // Set is ORed after the clear so a fresh edge survives a simultaneous W1C.
         status <= (status & ~w1c) | edge_set;
         irq    <= |status;
         if (wr) begin
            case (word)
               W_OUT:   out_r   <= (out_r   & ~wmask) | (wbits & wmask);
               W_DIR:   dir_r   <= (dir_r   & ~wmask) | (wbits & wmask);
               W_RISE:  rise_en <= (rise_en & ~wmask) | (wbits & wmask);
               W_FALL:  fall_en <= (fall_en & ~wmask) | (wbits & wmask);
               default: ;
            endcase
         end
      end
   end

`ifdef GPIO_PWM_EN
   assign duty_mask = lane_mask[PWM_BITS-1:0];
   assign duty_bits = iomem_wdata[PWM_BITS-1:0];

   always_ff @(posedge clk2) begin
      if (!resetn) begin
         cnt     <= '0;
         pwm_sel <= '0;
         pwm_q   <= '0;
         for (int i = 0; i < NUM_PINS; i++) duty[i] <= '0;
      end else begin
         cnt <= cnt + PWM_BITS'(1);
         if (wr && (word == W_PWMSEL)) pwm_sel <= (pwm_sel & ~wmask) | (wbits & wmask);
         for (int i = 0; i < NUM_PINS; i++) begin
            if (wr && (word == 6'(16 + i)))
               duty[i] <= (duty[i] & ~duty_mask) | (duty_bits & duty_mask);
            pwm_q[i] <= (cnt < duty[i]);
         end
      end
   end

   assign gpio_out = (pwm_sel & pwm_q) | (~pwm_sel & out_r);
`else
   assign gpio_out = out_r;
`endif

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// tb/tb_iomem_gpio_bank.sv - self-checking bench for iomem_gpio_bank (vector table, corner sequences, random vs model)
module tb_iomem_gpio_bank;

   localparam int          NP    = 16;
   localparam logic [31:0] PMASK = 32'h0000_FFFF;
   localparam logic [31:0] BASE  = 32'h0300_0000;
   localparam int          NV    = 16;

   logic          clk2 = 1'b0;
   logic          resetn = 1'b0;
   logic          iomem_valid = 1'b0;
   logic          iomem_ready;
   logic [3:0]    iomem_wstrb = 4'h0;
   logic [31:0]   iomem_addr = '0;
   logic [31:0]   iomem_wdata = '0;
   logic [31:0]   iomem_rdata;
   logic [NP-1:0] gpio_in = '0;
   logic [NP-1:0] gpio_out;
   logic [NP-1:0] gpio_oe;
   logic          irq;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0]  off;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rd;
      logic [15:0] exp_out;
      logic [15:0] exp_oe;
   } vec_t;

   vec_t vecs [NV];

   logic [7:0] woffs [7]  = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h1C};
   logic [7:0] roffs [11] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                              8'h18, 8'h1C, 8'h20, 8'h3C, 8'hC0};

   logic [31:0] m_out, m_dir, m_in, m_rise, m_fall, m_stat;

   iomem_gpio_bank #(.BASE_HI(8'h03), .NUM_PINS(NP), .PWM_BITS(8)) dut (
      .clk2        (clk2),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .gpio_in     (gpio_in),
      .gpio_out    (gpio_out),
      .gpio_oe     (gpio_oe),
      .irq         (irq)
   );

   always #5 clk2 = ~clk2;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r, output int lat);
      @(negedge clk2);
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wdata = d;
      iomem_wstrb = s;
      lat = 0;
      do begin
         @(posedge clk2);
         #1;
         lat++;
      end while (!iomem_ready && lat < 8);
      r = iomem_rdata;
      @(negedge clk2);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
   endtask

   function automatic void model_write(input logic [7:0] off, input logic [31:0] d,
                                       input logic [3:0] s);
      logic [31:0] m;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}} & PMASK;
      case (off)
         8'h00: m_out  = (m_out  & ~m) | (d & m);
         8'h04: m_dir  = (m_dir  & ~m) | (d & m);
         8'h0C: m_rise = (m_rise & ~m) | (d & m);
         8'h10: m_fall = (m_fall & ~m) | (d & m);
         8'h14: m_stat = m_stat & ~(d & m);
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] off);
      case (off)
         8'h00:   return m_out;
         8'h04:   return m_dir;
         8'h08:   return m_in;
         8'h0C:   return m_rise;
         8'h10:   return m_fall;
         8'h14:   return m_stat;
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      logic [31:0] r;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] nv;
      logic [3:0]  s;
      logic [7:0]  off;
      int          lat;
      int          act;
      int          hi;
      int          pulses;

      vecs[0]  = '{8'h00, 32'h0000A5A5, 4'h1, 32'h0,        16'h00A5, 16'h0000};
      vecs[1]  = '{8'h00, 32'h0,        4'h0, 32'h000000A5, 16'h00A5, 16'h0000};
      vecs[2]  = '{8'h04, 32'hFFFFFFFF, 4'hF, 32'h0,        16'h00A5, 16'hFFFF};
      vecs[3]  = '{8'h04, 32'h0,        4'h0, 32'h0000FFFF, 16'h00A5, 16'hFFFF};
      vecs[4]  = '{8'h00, 32'h12345678, 4'hC, 32'h0,        16'h00A5, 16'hFFFF};
      vecs[5]  = '{8'h00, 32'h0,        4'h0, 32'h000000A5, 16'h00A5, 16'hFFFF};
      vecs[6]  = '{8'h00, 32'h00001234, 4'h2, 32'h0,        16'h12A5, 16'hFFFF};
      vecs[7]  = '{8'h01, 32'h0,        4'h0, 32'h000012A5, 16'h12A5, 16'hFFFF};
      vecs[8]  = '{8'h04, 32'h000000F0, 4'h1, 32'h0,        16'h12A5, 16'hFFF0};
      vecs[9]  = '{8'h06, 32'h0,        4'h0, 32'h0000FFF0, 16'h12A5, 16'hFFF0};
      vecs[10] = '{8'h1C, 32'hFFFFFFFF, 4'hF, 32'h0,        16'h12A5, 16'hFFF0};
      vecs[11] = '{8'h1C, 32'h0,        4'h0, 32'h0,        16'h12A5, 16'hFFF0};
      vecs[12] = '{8'hC0, 32'h0,        4'h0, 32'h0,        16'h12A5, 16'hFFF0};
      vecs[13] = '{8'h08, 32'hFFFFFFFF, 4'hF, 32'h0,        16'h12A5, 16'hFFF0};
      vecs[14] = '{8'h08, 32'h0,        4'h0, 32'h0,        16'h12A5, 16'hFFF0};
      vecs[15] = '{8'h18, 32'h0,        4'h0, 32'h0,        16'h12A5, 16'hFFF0};

      // Reset with all pads high; arming must prevent spurious edges.
      gpio_in = 16'hFFFF;
      resetn  = 1'b0;
      repeat (4) @(posedge clk2);
      @(negedge clk2);
      chk("rst_ready", 32'(iomem_ready), 32'h0);
      chk("rst_rdata", iomem_rdata, 32'h0);
      chk("rst_gpio_out", 32'(gpio_out), 32'h0);
      chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      resetn = 1'b1;
      bus(BASE | 32'h0C, 32'h0000FFFF, 4'hF, r, lat);
      bus(BASE | 32'h10, 32'h0000FFFF, 4'hF, r, lat);
      repeat (8) @(negedge clk2);
      bus(BASE | 32'h14, 32'h0, 4'h0, r, lat);
      chk("arm_status", r, 32'h0);
      bus(BASE | 32'h08, 32'h0, 4'h0, r, lat);
      chk("arm_in", r, 32'h0000FFFF);
      chk("arm_irq", 32'(irq), 32'h0);
      bus(BASE | 32'h0C, 32'h0, 4'hF, r, lat);
      bus(BASE | 32'h10, 32'h0, 4'hF, r, lat);
      gpio_in = '0;
      repeat (6) @(negedge clk2);

      for (int i = 0; i < NV; i++) begin
         bus(BASE | 32'(vecs[i].off), vecs[i].wdata, vecs[i].wstrb, r, lat);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
         if (vecs[i].wstrb == 4'h0) chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rd);
         chk($sformatf("vec%0d_gpio_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
         chk($sformatf("vec%0d_gpio_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
      end

      // Held request: ready pulses every other cycle.
      @(negedge clk2);
      iomem_valid = 1'b1;
      iomem_addr  = BASE;
      iomem_wstrb = 4'h0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk2);
         #1;
         chk($sformatf("b2b_ready%0d", k), 32'(iomem_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      @(negedge clk2);
      iomem_valid = 1'b0;

      // Foreign BASE_HI is never acknowledged.
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0400_0000;
      hi = 0;
      repeat (3) begin
         @(posedge clk2);
         #1;
         if (iomem_ready) hi++;
      end
      chk("foreign_base_ready", 32'(hi), 32'd0);
      @(negedge clk2);
      iomem_valid = 1'b0;

      // Rising edge on pin 0: STATUS sets on the 3rd edge, irq one edge later.
      bus(BASE | 32'h0C, 32'h1, 4'h1, r, lat);
      @(negedge clk2);
      gpio_in[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk2);
         #1;
         chk($sformatf("edge_irq_e%0d", k), 32'(irq), (k == 3) ? 32'd1 : 32'd0);
      end
      bus(BASE | 32'h14, 32'h0, 4'h0, r, lat);
      chk("edge_status", r, 32'h1);
      bus(BASE | 32'h14, 32'h1, 4'h1, r, lat);
      repeat (2) @(negedge clk2);
      bus(BASE | 32'h14, 32'h0, 4'h0, r, lat);
      chk("w1c_status", r, 32'h0);
      chk("w1c_irq", 32'(irq), 32'h0);

      // W1C landing on the same edge that captures a new rising edge.
      gpio_in[0] = 1'b0;
      repeat (6) @(negedge clk2);
      bus(BASE | 32'h14, 32'h0, 4'h0, r, lat);
      chk("fall_ignored_status", r, 32'h0);
      @(negedge clk2);
      gpio_in[0] = 1'b1;
      @(posedge clk2);
      @(posedge clk2);
      @(negedge clk2);
      iomem_valid = 1'b1;
      iomem_addr  = BASE | 32'h14;
      iomem_wdata = 32'h1;
      iomem_wstrb = 4'h1;
      @(posedge clk2);
      #1;
      chk("collide_ready", 32'(iomem_ready), 32'h1);
      @(negedge clk2);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      bus(BASE | 32'h14, 32'h0, 4'h0, r, lat);
      chk("collide_status", r, 32'h1);
      bus(BASE | 32'h14, 32'h0000FF00, 4'h2, r, lat);
      bus(BASE | 32'h14, 32'h0, 4'h0, r, lat);
      chk("w1c_lane_gated", r, 32'h1);
      bus(BASE | 32'h14, 32'h1, 4'h1, r, lat);
      bus(BASE | 32'h0C, 32'h0, 4'hF, r, lat);

`ifdef GPIO_PWM_EN
      bus(BASE | 32'h18, 32'h1, 4'h1, r, lat);
      bus(BASE | 32'h40, 32'd64, 4'h1, r, lat);
      repeat (4) @(negedge clk2);
      pulses = 0;
      repeat (256) begin
         @(negedge clk2);
         pulses += int'(gpio_out[0]);
      end
      chk("pwm_duty64", 32'(pulses), 32'd64);
      bus(BASE | 32'h40, 32'd0, 4'h1, r, lat);
      repeat (4) @(negedge clk2);
      pulses = 0;
      repeat (256) begin
         @(negedge clk2);
         pulses += int'(gpio_out[0]);
      end
      chk("pwm_duty0", 32'(pulses), 32'd0);
      bus(BASE | 32'hC0, 32'h0, 4'h0, r, lat);
      chk("pwm_c0_read", r, 32'h0);
      bus(BASE | 32'h18, 32'h0, 4'h1, r, lat);
`endif

      // Reset arriving together with a request: dropped, no ready.
      bus(BASE | 32'h00, 32'h0000FFFF, 4'hF, r, lat);
      @(negedge clk2);
      iomem_valid = 1'b1;
      iomem_addr  = BASE;
      iomem_wdata = 32'h00001234;
      iomem_wstrb = 4'hF;
      resetn      = 1'b0;
      @(posedge clk2);
      #1;
      chk("midrst_ready", 32'(iomem_ready), 32'h0);
      chk("midrst_gpio_out", 32'(gpio_out), 32'h0);
      chk("midrst_gpio_oe", 32'(gpio_oe), 32'h0);
      @(negedge clk2);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      resetn      = 1'b1;
      bus(BASE, 32'h0, 4'h0, r, lat);
      chk("midrst_out", r, 32'h0);

      // Random bus traffic and pad activity against the register-level model.
      repeat (6) @(negedge clk2);
      m_out = 0; m_dir = 0; m_rise = 0; m_fall = 0; m_stat = 0;
      m_in = 32'(gpio_in);
      for (int it = 0; it < 200; it++) begin
         act = $urandom_range(0, 9);
         if (act < 4) begin
            off = woffs[$urandom_range(0, 6)];
            d   = $urandom;
            s   = 4'($urandom_range(1, 15));
            a   = {8'h03, 16'($urandom), off | 8'($urandom_range(0, 3))};
            bus(a, d, s, r, lat);
            model_write(off, d, s);
            chk("rnd_wr_latency", 32'(lat), 32'd1);
            chk("rnd_gpio_out", 32'(gpio_out), m_out);
            chk("rnd_gpio_oe", 32'(gpio_oe), m_dir);
         end else if (act < 8) begin
            off = roffs[$urandom_range(0, 10)];
            a   = {8'h03, 16'($urandom), off | 8'($urandom_range(0, 3))};
            bus(a, 32'($urandom), 4'h0, r, lat);
            chk($sformatf("rnd_rd_%02h", off), r, model_read(off));
            chk("rnd_irq", 32'(irq), 32'(|m_stat));
         end else begin
            nv = $urandom & PMASK;
            gpio_in = nv[NP-1:0];
            repeat (6) @(negedge clk2);
            m_stat = m_stat | ((nv & ~m_in) & m_rise) | ((~nv & m_in & PMASK) & m_fall);
            m_in   = nv;
            chk("rnd_pin_irq", 32'(irq), 32'(|m_stat));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
